// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Every output is registered. Each digit slot opens with a dead-time window in which all anodes are off.
module seg_scan_ctrl #(
    parameter int CLK_DIV     = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        tick
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_W   = CW'(DEAD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]    idx_r, idx_nxt_s;
    logic          slot_start_s;
    logic          in_dead_s;
    logic          blank_eff_s;
    logic          blank_hold_r;
    logic [3:0]    nib_s;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic          tick_r;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next slot position, next state and slot-start detection
    always_comb begin
        cnt_nxt_s    = cnt_r;
        idx_nxt_s    = idx_r;
        slot_start_s = 1'b0;
        if (!en) begin
            cnt_nxt_s = {CW{1'b0}};
            idx_nxt_s = 2'd0;
        end else if (state_r == IDLE) begin
            cnt_nxt_s    = {CW{1'b0}};
            idx_nxt_s    = 2'd0;
            slot_start_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s    = {CW{1'b0}};
            idx_nxt_s    = idx_r + 2'd1;
            slot_start_s = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end

        in_dead_s = (DEAD_CYCLES != 0) && (cnt_nxt_s < DEAD_W);

        if (!en) begin
            state_nxt_s = IDLE;
        end else if (in_dead_s) begin
            state_nxt_s = BLANK;
        end else begin
            state_nxt_s = DRIVE;
        end

        // The blank mask is taken live on the slot's first cycle, then held.
        if (slot_start_s) begin
            blank_eff_s = blank[idx_nxt_s];
        end else begin
            blank_eff_s = blank_hold_r;
        end
        nib_s = digits[{idx_nxt_s, 2'b00} +: 4];
    end

    // State, slot counter and digit index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Output registers, loaded from next-state values so they line up with the slot they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r         <= 4'b1111;
            seg_r        <= 7'b1111111;
            dp_r         <= 1'b1;
            tick_r       <= 1'b0;
            blank_hold_r <= 1'b0;
        end else if (state_nxt_s == IDLE) begin
            an_r         <= 4'b1111;
            seg_r        <= 7'b1111111;
            dp_r         <= 1'b1;
            tick_r       <= 1'b0;
            blank_hold_r <= 1'b0;
        end else begin
            if (slot_start_s) begin
                seg_r        <= hex7(nib_s);
                dp_r         <= ~dp_in[idx_nxt_s];
                blank_hold_r <= blank[idx_nxt_s];
            end else begin
                seg_r        <= seg_r;
                dp_r         <= dp_r;
                blank_hold_r <= blank_hold_r;
            end
            if ((state_nxt_s == DRIVE) && !blank_eff_s) begin
                an_r <= ~(4'b0001 << idx_nxt_s);
            end else begin
                an_r <= 4'b1111;
            end
            tick_r <= (cnt_nxt_s == CNT_LAST);
        end
    end

    assign an        = an_r;
    assign seg       = seg_r;
    assign dp        = dp_r;
    assign digit_sel = idx_r;
    assign tick      = tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (CLK_DIV=8, DEAD_CYCLES=2).
// A behavioural slot model pushes expected outputs per edge; they are popped and compared at the next falling edge.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        tick;

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .digits(digits), .dp_in(dp_in),
        .blank(blank), .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // model state
    bit         m_act = 1'b0;
    int         m_cnt = 0;
    int         m_idx = 0;
    logic [6:0] m_seg = 7'h7F;
    logic       m_dp = 1'b0;
    logic       m_bl = 1'b0;

    logic [14:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance the model over one rising edge with the present inputs; push expected {an,seg,dp,sel,tick}
    task automatic model_push();
        bit         start;
        logic [3:0] e_an;
        logic [3:0] nib;
        start = 1'b0;
        if (!reset_n || !en) begin
            m_act = 1'b0; m_cnt = 0; m_idx = 0;
        end else if (!m_act) begin
            m_act = 1'b1; m_cnt = 0; m_idx = 0; start = 1'b1;
        end else if (m_cnt == CLK_DIV - 1) begin
            m_cnt = 0; m_idx = (m_idx + 1) % 4; start = 1'b1;
        end else begin
            m_cnt++;
        end
        if (start) begin
            nib   = digits[4*m_idx +: 4];
            m_seg = seg_tab[nib];
            m_dp  = dp_in[m_idx];
            m_bl  = blank[m_idx];
        end
        if (!m_act) begin
            exp_q.push_back({4'b1111, 7'b1111111, 1'b1, 2'd0, 1'b0});
        end else begin
            e_an = 4'b1111;
            if (m_cnt >= DEAD && !m_bl) e_an[m_idx] = 1'b0;
            exp_q.push_back({e_an, m_seg, ~m_dp, 2'(m_idx), (m_cnt == CLK_DIV - 1)});
        end
    endtask

    task automatic step();
        logic [14:0] e;
        model_push();
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("an",        32'(an),        32'(e[14:11]));
            check_val("seg",       32'(seg),       32'(e[10:4]));
            check_val("dp",        32'(dp),        32'(e[3]));
            check_val("digit_sel", 32'(digit_sel), 32'(e[2:1]));
            check_val("tick",      32'(tick),      32'(e[0]));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model sits at the given slot position (bounded)
    task automatic run_until(input int idx, input int cnt);
        int guard;
        guard = 0;
        while (!(m_act && m_idx == idx && m_cnt == cnt) && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check_val("align_timeout", 32'(guard), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_an"},   32'(an),        32'h0000000F);
        check_val({tag, "_seg"},  32'(seg),       32'h0000007F);
        check_val({tag, "_dp"},   32'(dp),        32'd1);
        check_val({tag, "_sel"},  32'(digit_sel), 32'd0);
        check_val({tag, "_tick"}, 32'(tick),      32'd0);
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("rst0");
        @(negedge clk);
        run(2);
        reset_n = 1'b1;
        run(1);

        // basic scan of 1234
        digits = 16'h1234;
        en     = 1'b1;
        run(40);

        // decode: one value per frame in slot0, with a mid-slot disturbance
        for (int v = 0; v < 16; v++) begin
            run_until(3, CLK_DIV - 1);
            digits[3:0] = 4'(v);
            run(3);
            digits[3:0] = ~4'(v);
            run(5);
        end

        // blank and decimal-point masks
        digits = 16'hA5C7;
        blank  = 4'b0100;
        dp_in  = 4'b0001;
        run(40);
        blank  = 4'b0000;
        dp_in  = 4'b0000;
        run(8);

        // enable drop in cycle 5 of slot1, then restart
        run_until(1, 4);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(12);

        // reset mid-DRIVE in slot3, held 3 cycles, released with en=1
        run_until(3, 4);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        exp_q.delete();
        m_act = 1'b0; m_cnt = 0; m_idx = 0;
        @(negedge clk);
        run(3);
        reset_n = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
